// File: rtl/mult_sequencer_if.sv
// Bus between the ID/EX stage, the ALU and the iterative multiplier.
// Carries the multiply request and operands, the pipeline ALU request, the
// ALU request/result path, and the multiplier status and result.
// master: pipeline/ALU side (drives *_i). slave: mult_sequencer (drives *_o).
interface mult_sequencer_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;

    logic              start_i;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic [DATA_W-1:0] pipe_data1_i;
    logic [DATA_W-1:0] pipe_data2_i;
    logic [CTRL_W-1:0] pipe_ctrl_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] alu_data1_o;
    logic [DATA_W-1:0] alu_data2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, op_a_i, op_b_i, pipe_data1_i, pipe_data2_i, pipe_ctrl_i,
               alu_result_i,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o, stall_o, busy_o, done_o,
               hi_o, lo_o
    );

    modport slave (
        input  start_i, op_a_i, op_b_i, pipe_data1_i, pipe_data2_i, pipe_ctrl_i,
               alu_result_i,
        output alu_data1_o, alu_data2_o, alu_ctrl_o, stall_o, busy_o, done_o,
               hi_o, lo_o
    );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative unsigned 32x32->64 multiplier that borrows the pipeline ALU.
// Idle: pipeline operands/control pass straight through to the ALU.
// Run: 32 shift-add iterations using the ALU as the adder, pipeline stalled.
// Done: one-cycle done pulse with HI/LO registered.
// Ports: clk_i, rst_i (async, active-high), bus (mult_sequencer_if.slave).
module mult_sequencer (
    input  logic            clk_i,
    input  logic            rst_i,
    mult_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [CNT_W-1:0]  CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] p_hi_q, p_hi_d;
    logic [DATA_W-1:0] p_lo_q, p_lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] sum_c;
    logic              carry_c;
    logic [DATA_W-1:0] alu_data1_c;
    logic [DATA_W-1:0] alu_data2_c;
    logic [CTRL_W-1:0] alu_ctrl_c;
    logic              stall_c;

    // Partial-sum step: the ALU adds A into P_hi; the carry-out is recovered
    // locally because the ALU only returns 32 bits.
    always_comb begin
        sum_c   = p_hi_q;
        carry_c = 1'b0;
        if (p_lo_q[0]) begin
            sum_c   = bus.alu_result_i;
            carry_c = (bus.alu_result_i < p_hi_q);
        end
    end

    // Next-state, datapath update and ALU ownership mux.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        alu_data1_c = bus.pipe_data1_i;
        alu_data2_c = bus.pipe_data2_i;
        alu_ctrl_c  = bus.pipe_ctrl_i;
        stall_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Stall is suppressed while in reset so the pipeline is not frozen.
                if (bus.start_i && !rst_i) begin
                    stall_c = 1'b1;
                end
                if (bus.start_i) begin
                    state_d = RUN;
                    a_d     = bus.op_a_i;
                    p_hi_d  = '0;
                    p_lo_d  = bus.op_b_i;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                alu_data1_c = p_hi_q;
                alu_data2_c = a_q;
                alu_ctrl_c  = ALU_ADD;
                stall_c     = 1'b1;
                // 65-bit right shift of {carry, sum, P_lo}.
                {p_hi_d, p_lo_d} = {carry_c, sum_c, p_lo_q[DATA_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    hi_d    = {carry_c, sum_c[DATA_W-1:1]};
                    lo_d    = {sum_c[0], p_lo_q[DATA_W-1:1]};
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.alu_data1_o = alu_data1_c;
    assign bus.alu_data2_o = alu_data2_c;
    assign bus.alu_ctrl_o  = alu_ctrl_c;
    assign bus.stall_o     = stall_c;
    assign bus.busy_o      = (state_q == RUN);
    assign bus.done_o      = done_q;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed product table, ignored
// starts, async reset mid-run, and random operands against a 64-bit product.
module tb_mult_sequencer;
    logic clk_i = 1'b0;
    logic rst_i;

    mult_sequencer_if bus ();

    mult_sequencer dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Combinational ALU model.
    always_comb begin
        case (bus.alu_ctrl_o)
            3'b000:  bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
            3'b001:  bus.alu_result_i = bus.alu_data1_o | bus.alu_data2_o;
            3'b010:  bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
            3'b110:  bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
            default: bus.alu_result_i = '0;
        endcase
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One multiply: accept at the next posedge, track the run, return the result.
    // inj pulses start during RUN cycle 10 and during the DONE cycle.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit inj,
                           output logic [31:0] rh, output logic [31:0] rl);
        int busy_n, done_n, done_k, bad_run, bad_done;
        busy_n = 0; done_n = 0; done_k = 0; bad_run = 0; bad_done = 0;
        rh = 'x; rl = 'x;
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.op_a_i  = a;
        bus.op_b_i  = b;
        #1;
        check("accept_stall", 64'(bus.stall_o), 64'd1);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk_i);
            bus.pipe_data1_i = $urandom;
            bus.pipe_data2_i = $urandom;
            bus.pipe_ctrl_i  = 3'b001;
            if (inj && k == 10) begin bus.start_i = 1'b1; bus.op_a_i = ~a; bus.op_b_i = ~b; end
            if (inj && k == 11) bus.start_i = 1'b0;
            if (inj && k == 33) begin bus.start_i = 1'b1; bus.op_a_i = ~a; end
            if (inj && k == 34) bus.start_i = 1'b0;
            #1;
            if (bus.busy_o) begin
                busy_n++;
                if (bus.alu_ctrl_o !== 3'b010 || bus.alu_data2_o !== a || bus.stall_o !== 1'b1)
                    bad_run++;
            end
            if (bus.done_o) begin
                done_n++;
                done_k = k;
                rh = bus.hi_o;
                rl = bus.lo_o;
                if (bus.stall_o !== 1'b0 || bus.alu_ctrl_o !== 3'b001 ||
                    bus.alu_data1_o !== bus.pipe_data1_i)
                    bad_done++;
            end
            if (done_n > 0 && (!inj || k >= 36)) break;
        end
        check("busy_cycles", 64'(busy_n), 64'd32);
        check("done_pulses", 64'(done_n), 64'd1);
        check("done_latency", 64'(done_k), 64'd33);
        check("run_alu_drive", 64'(bad_run), 64'd0);
        check("done_cycle_pass", 64'(bad_done), 64'd0);
        if (inj) check("hold_after_ignored", {bus.hi_o, bus.lo_o}, {rh, rl});
    endtask

    vec_t vecs[7];
    logic [31:0] rh, rl, ra, rb;
    logic [63:0] prod;
    int spurious;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'd2,          32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'd0,          32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        rst_i = 1'b1;
        bus.start_i = 1'b1;
        bus.op_a_i = '0; bus.op_b_i = '0;
        bus.pipe_data1_i = 32'd7; bus.pipe_data2_i = 32'd9; bus.pipe_ctrl_i = 3'b001;
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_pass", {29'd0, bus.alu_ctrl_o, bus.alu_data1_o}, {29'd0, 3'b001, 32'd7});
        @(negedge clk_i);
        bus.start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Idle pass-through.
        bus.pipe_data1_i = 32'd7; bus.pipe_data2_i = 32'd9; bus.pipe_ctrl_i = 3'b001;
        #1;
        check("idle_pass_d1", 64'(bus.alu_data1_o), 64'd7);
        check("idle_pass_d2", 64'(bus.alu_data2_o), 64'd9);
        check("idle_pass_ctrl", 64'(bus.alu_ctrl_o), 64'd1);
        check("idle_stall", 64'(bus.stall_o), 64'd0);

        // Directed product table, back-to-back.
        for (int i = 0; i < 7; i++) begin
            do_mult(vecs[i].a, vecs[i].b, 1'b0, rh, rl);
            check($sformatf("table_%0d", i), {rh, rl}, {vecs[i].hi, vecs[i].lo});
        end

        // Starts during RUN and DONE are ignored; next start right after is accepted.
        do_mult(32'h0000_1234, 32'h0000_5678, 1'b1, rh, rl);
        check("ignored_start_result", {rh, rl}, 64'h0000_0000_0626_0060);
        do_mult(32'd6, 32'd7, 1'b0, rh, rl);
        check("accept_after_done", {rh, rl}, 64'd42);

        // Async reset at RUN cycle 15.
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.op_a_i = 32'hDEAD_BEEF; bus.op_b_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (14) @(negedge clk_i);
        #2;
        check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        rst_i = 1'b1;
        bus.start_i = 1'b1;
        bus.pipe_data1_i = 32'd7; bus.pipe_data2_i = 32'd9; bus.pipe_ctrl_i = 3'b001;
        #1;
        check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check("mid_rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check("mid_rst_stall", 64'(bus.stall_o), 64'd0);
        check("mid_rst_pass", {bus.alu_data1_o, bus.alu_data2_o}, {32'd7, 32'd9});
        @(negedge clk_i);
        bus.start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.done_o || bus.busy_o) spurious++;
        end
        check("post_rst_quiet", 64'(spurious), 64'd0);
        check("post_rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

        // Random operands against the full-width product.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 3) ra = '0;
            if (i % 10 == 7) rb = 32'hFFFF_FFFF;
            prod = 64'(ra) * 64'(rb);
            do_mult(ra, rb, 1'b0, rh, rl);
            check($sformatf("rand_%0d_%h_x_%h", i, ra, rb), {rh, rl}, prod);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
